// File: rtl/instr_fetch_queue_pkg.sv
// Shared types, defaults and helpers for the instruction fetch queue.
package instr_fetch_queue_pkg;

  typedef enum logic [0:0] {
    FQ_RUN   = 1'b0,
    FQ_DRAIN = 1'b1
  } fq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  localparam int FQ_DEPTH_DEFAULT           = 4;
  localparam int FQ_MAX_OUTSTANDING_DEFAULT = 2;

  function automatic logic [31:0] fq_word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO: head visible combinationally from registered storage.
// Push into a full FIFO is legal only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (push && !flush) mem[wr_ptr] <= push_dat;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch-to-memory request issue with in-order response capture into a Decode FIFO.
// rvalid in cycle N gives instr_valid_op in N+1; issue is credit-limited so the FIFO never overflows.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH           = FQ_DEPTH_DEFAULT,
  parameter int MAX_OUTSTANDING = FQ_MAX_OUTSTANDING_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_req_ip,
  input  logic [31:0] instr_addr_ip,
  output logic        fetch_stall_op,
  input  logic        flush_ip,
  output logic        mem_req_op,
  output logic [31:0] mem_addr_op,
  input  logic        mem_gnt_ip,
  input  logic        mem_rvalid_ip,
  input  logic [31:0] mem_rdata_ip,
  output logic        instr_valid_op,
  output logic [31:0] instr_op,
  output logic [31:0] instr_pc_op,
  input  logic        instr_ready_ip,
  output logic        err_op
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  fq_state_e   state;
  logic [OW-1:0] discard;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] remaining;
  logic [CW-1:0] fifo_count;
  logic        addr_full, addr_empty;
  logic        instr_full, instr_empty;
  logic [31:0] head_addr;
  fq_entry_t   head_entry;
  fq_entry_t   push_entry;
  logic        can_issue, grant, rsp_ok, rsp_keep, instr_pop;

  // The address FIFO count is the outstanding count; full means the request limit is reached.
  assign can_issue = (state == FQ_RUN) & ~flush_ip & ~addr_full &
                     ((int'(fifo_count) + int'(outstanding)) < DEPTH);

  assign mem_req_op     = reset & instr_req_ip & can_issue;
  assign mem_addr_op    = fq_word_align(instr_addr_ip);
  assign grant          = mem_req_op & mem_gnt_ip;
  assign fetch_stall_op = reset & instr_req_ip & ~grant;

  assign rsp_ok     = mem_rvalid_ip & ~addr_empty;
  assign rsp_keep   = rsp_ok & ~flush_ip & (discard == '0);
  assign remaining  = outstanding - OW'(rsp_ok);
  assign push_entry = '{pc: head_addr, instr: mem_rdata_ip};

  assign instr_valid_op = ~instr_empty;
  assign instr_pop      = instr_valid_op & instr_ready_ip & ~flush_ip;
  assign instr_op       = instr_valid_op ? head_entry.instr : '0;
  assign instr_pc_op    = instr_valid_op ? head_entry.pc    : '0;

  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_addr_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (1'b0),
    .push     (grant),
    .push_dat (mem_addr_op),
    .pop      (rsp_ok),
    .pop_dat  (head_addr),
    .full     (addr_full),
    .empty    (addr_empty),
    .count    (outstanding)
  );

  sync_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(DEPTH)) u_instr_fifo (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush_ip),
    .push     (rsp_keep),
    .push_dat (push_entry),
    .pop      (instr_pop),
    .pop_dat  (head_entry),
    .full     (instr_full),
    .empty    (instr_empty),
    .count    (fifo_count)
  );

  // Responses still in flight at a redirect are counted in discard and dropped on arrival.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= FQ_RUN;
      discard <= '0;
      err_op  <= 1'b0;
    end else begin
      if (mem_rvalid_ip && addr_empty) err_op <= 1'b1;
      if (flush_ip) begin
        discard <= remaining;
        state   <= (remaining != '0) ? FQ_DRAIN : FQ_RUN;
      end else if (state == FQ_DRAIN && rsp_ok) begin
        discard <= discard - OW'(1);
        if (discard == OW'(1)) state <= FQ_RUN;
      end
    end
  end

  a_credit_holds: assert property (@(posedge clock) disable iff (!reset)
    !(rsp_keep && instr_full && !instr_pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised and directed bench for instr_fetch_queue with a queue-based memory/Decode model.
module tb_instr_fetch_queue;
  import instr_fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_req_ip = 1'b0;
  logic [31:0] instr_addr_ip = '0;
  logic        fetch_stall_op;
  logic        flush_ip = 1'b0;
  logic        mem_req_op;
  logic [31:0] mem_addr_op;
  logic        mem_gnt_ip = 1'b0;
  logic        mem_rvalid_ip = 1'b0;
  logic [31:0] mem_rdata_ip = '0;
  logic        instr_valid_op;
  logic [31:0] instr_op;
  logic [31:0] instr_pc_op;
  logic        instr_ready_ip = 1'b0;
  logic        err_op;

  always #5 clock = ~clock;

  instr_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clock          (clock),
    .reset          (reset),
    .instr_req_ip   (instr_req_ip),
    .instr_addr_ip  (instr_addr_ip),
    .fetch_stall_op (fetch_stall_op),
    .flush_ip       (flush_ip),
    .mem_req_op     (mem_req_op),
    .mem_addr_op    (mem_addr_op),
    .mem_gnt_ip     (mem_gnt_ip),
    .mem_rvalid_ip  (mem_rvalid_ip),
    .mem_rdata_ip   (mem_rdata_ip),
    .instr_valid_op (instr_valid_op),
    .instr_op       (instr_op),
    .instr_pc_op    (instr_pc_op),
    .instr_ready_ip (instr_ready_ip),
    .err_op         (err_op)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; bit stale; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  flight_t     inflight[$];
  exp_t        sb[$];
  bit          model_err  = 0;
  bit          pushed_now = 0;
  bit          last_stall = 0;
  logic [31:0] pc = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'hA0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle, entered at posedge+1. rv_mode: 0 none, 1 respond if anything is in flight, 2 force rvalid.
  task automatic cyc(input bit req, input bit gnt, input int rv_mode, input bit fl, input bit rdy,
                     input logic [31:0] redirect);
    bit      exp_req, rv;
    int      nstale;
    flight_t f;
    pushed_now = 0;
    chk("err_op", err_op, model_err);
    rv = (rv_mode == 2) || (rv_mode == 1 && inflight.size() > 0);
    instr_req_ip   = req;
    instr_addr_ip  = pc | ($urandom & 32'h3);
    mem_gnt_ip     = gnt;
    flush_ip       = fl;
    instr_ready_ip = rdy;
    mem_rvalid_ip  = rv;
    mem_rdata_ip   = (rv && inflight.size() > 0) ? inflight[0].data : $urandom;
    #1;
    nstale = 0;
    foreach (inflight[i]) if (inflight[i].stale) nstale++;
    exp_req = req && !fl && nstale == 0 && inflight.size() < MAXO &&
              (sb.size() + inflight.size()) < DEPTH;
    chk("mem_req_op", mem_req_op, exp_req);
    chk("fetch_stall_op", fetch_stall_op, req && !(exp_req && gnt));
    if (req) chk("mem_addr_op", mem_addr_op, pc);
    last_stall = req && !(exp_req && gnt);
    if (rv) begin
      if (inflight.size() == 0) model_err = 1;
      else begin
        f = inflight.pop_front();
        if (!f.stale && !fl) begin
          sb.push_back('{f.addr, f.data});
          pushed_now = 1;
        end
      end
    end
    if (fl) begin
      foreach (inflight[i]) inflight[i].stale = 1;
      sb.delete();
    end
    if (exp_req && gnt) begin
      inflight.push_back('{pc, mem_word(pc), 1'b0});
      pc += 32'd4;
    end
    if (fl) pc = redirect;
    @(posedge clock);
    #1;
  endtask

  // Decode-side monitor: compares each consumed head against the scoreboard.
  initial begin : monitor
    int   committed;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && !flush_ip) begin
        committed = sb.size() - int'(pushed_now);
        chk("instr_valid_op", instr_valid_op, committed > 0);
        if (instr_valid_op && instr_ready_ip && committed > 0) begin
          e = sb.pop_front();
          chk("instr_pc_op", instr_pc_op, e.pc);
          chk("instr_op", instr_op, e.instr);
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin : stim
    bit req;
    int guard;
    // Reset state, with Fetch already requesting.
    instr_req_ip = 1'b1;
    #3;
    chk("rst mem_req_op", mem_req_op, 0);
    chk("rst fetch_stall_op", fetch_stall_op, 0);
    chk("rst instr_valid_op", instr_valid_op, 0);
    chk("rst instr_op", instr_op, 0);
    chk("rst instr_pc_op", instr_pc_op, 0);
    chk("rst err_op", err_op, 0);
    #9 reset = 1'b1;
    @(posedge clock);
    #1;

    // Steady stream: 0x00,0x04,0x08 with responses one cycle after grant.
    pc = 32'h0;
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    cyc(0, 1, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Backpressure until the FIFO fills, then a single Decode pop frees one credit.
    pc = 32'h0;
    cyc(1, 1, 0, 0, 0, 0);
    repeat (5) cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 0, 0);
    repeat (8) cyc(0, 0, 1, 0, 1, 0);

    // Grant stall on 0x20.
    pc = 32'h20;
    repeat (3) cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Flush with two requests in flight, redirect to 0x100.
    pc = 32'h40;
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 1, 32'h100);
    cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 1, 0, 1, 0);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Flush coinciding with the only outstanding response, FIFO holding one entry.
    pc = 32'h60;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 1, 1, 32'h200);
    cyc(1, 1, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    // Randomised traffic; Fetch holds its request while stalled.
    for (int i = 0; i < 3000; i++) begin
      req = last_stall ? 1'b1 : ($urandom_range(0, 3) != 0);
      cyc(req, $urandom_range(0, 2) != 0, ($urandom_range(0, 1) != 0) ? 1 : 0,
          $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
          {$urandom_range(0, 32'h3FFF), 2'b00});
    end
    guard = 0;
    while ((inflight.size() > 0 || sb.size() > 0) && guard < 40) begin
      cyc(0, 0, 1, 0, 1, 0);
      guard++;
    end
    chk("drained", sb.size() + inflight.size(), 0);

    // Spurious response with nothing outstanding.
    cyc(0, 0, 2, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-burst, away from any clock edge.
    pc = 32'h300;
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst mem_req_op", mem_req_op, 0);
    chk("arst fetch_stall_op", fetch_stall_op, 0);
    chk("arst instr_valid_op", instr_valid_op, 0);
    chk("arst instr_op", instr_op, 0);
    chk("arst instr_pc_op", instr_pc_op, 0);
    chk("arst err_op", err_op, 0);
    inflight.delete();
    sb.delete();
    model_err  = 0;
    pushed_now = 0;
    last_stall = 0;
    instr_req_ip  = 1'b0;
    mem_gnt_ip    = 1'b0;
    mem_rvalid_ip = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    cyc(0, 0, 2, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
